// File: rtl/script_runner.sv
// -----------------------------------------------------------------------------
// script_runner
//
// Purpose:
//   Reads a script one 16-bit word at a time from the script memory and runs
//   it. Drives the memory pc, sends command bytes downstream over a
//   valid/ready handshake, and supports timed waits, jumps and halt.
//
//   Instruction word: op = script[15:14], arg = script[7:0]
//     00 CMD  : emit arg as a command byte
//     01 WAIT : stall for arg * TICK_CYCLES clocks (arg = 0 means no stall)
//     10 JUMP : pc <= arg (an odd target sets err and stops)
//     11 HALT : normal completion
//
// Handshake:
//   cmd_bits/cmd_valid are registered. Once cmd_valid rises, both hold
//   steady until a cycle where cmd_valid & cmd_ready are both high. That
//   cycle is the transfer, and cmd_valid drops on the next edge.
//
// Optional feature (macro SCRIPT_LOOP_EN):
//   When defined, JUMP reads script[13:8] as a repeat count N. N = 0 means
//   the jump is always taken. N > 0 means the jump is taken N times and then
//   falls through. There is a single loop counter, so loops cannot nest.
//   When undefined, script[13:8] is ignored and no loop counter is built.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   script_mode  in   memory is loading; forces abort to IDLE
//   script_num   in   [7:0]  script length in bytes
//   script       in   [15:0] word at pc (combinational memory read)
//   start        in   one-cycle pulse; starts at pc = 0
//   pc           out  [7:0]  byte address into the script memory (always even)
//   cmd_bits     out  [7:0]  command byte
//   cmd_valid    out  cmd_bits valid
//   cmd_ready    in   downstream accepts
//   busy         out  high in every state except IDLE and DONE
//   done         out  one-cycle pulse on normal completion
//   err          out  sticky odd-jump error; cleared by start or reset
//   state_dbg    out  [2:0]  current FSM state, for observation
// -----------------------------------------------------------------------------
module script_runner #(
    parameter int TICK_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        script_mode,
    input  logic [7:0]  script_num,
    input  logic [15:0] script,
    input  logic        start,
    output logic [7:0]  pc,
    output logic [7:0]  cmd_bits,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  state_dbg
);

    localparam int            PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    localparam logic [1:0] OP_CMD  = 2'b00;
    localparam logic [1:0] OP_WAIT = 2'b01;
    localparam logic [1:0] OP_JUMP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_EMIT  = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    pc_q, pc_d;
    logic [7:0]    cmd_bits_q, cmd_bits_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    wait_q, wait_d;
    logic [PW-1:0] presc_q, presc_d;

    logic [1:0]    op;
    logic [7:0]    arg;
    logic [7:0]    pc_next;
    logic          last_word;

    assign op      = script[15:14];
    assign arg     = script[7:0];
    assign pc_next = pc_q + 8'd2;
    // The current word is inside the script only when its odd byte
    // (pc + 1) is still below script_num. The compare is 9 bits wide so a
    // pc of 8'hFF cannot wrap around and pass the check.
    assign last_word = ({1'b0, pc_q} + 9'd1) >= {1'b0, script_num};

`ifdef SCRIPT_LOOP_EN
    logic [5:0] loop_q, loop_d;
    logic [5:0] rep;
    assign rep = script[13:8];
`else
    logic unused_rep;
    assign unused_rep = ^script[13:8];
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cmd_bits_d  = cmd_bits_q;
        cmd_valid_d = cmd_valid_q;
        done_d      = 1'b0;
        err_d       = err_q;
        wait_d      = wait_q;
        presc_d     = presc_q;
`ifdef SCRIPT_LOOP_EN
        loop_d      = loop_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (script_num >= 8'd2) begin
                        pc_d    = 8'd0;
                        presc_d = '0;
                        wait_d  = 8'd0;
`ifdef SCRIPT_LOOP_EN
                        loop_d  = 6'd0;
`endif
                        state_d = S_FETCH;
                    end else begin
                        // A script too short to hold one word finishes at once.
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                if (last_word) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    case (op)
                        OP_CMD: begin
                            cmd_bits_d  = arg;
                            cmd_valid_d = 1'b1;
                            state_d     = S_EMIT;
                        end
                        OP_WAIT: begin
                            if (arg == 8'd0) begin
                                pc_d    = pc_next;
                                state_d = S_FETCH;
                            end else begin
                                wait_d  = arg;
                                presc_d = '0;
                                state_d = S_WAIT;
                            end
                        end
                        OP_JUMP: begin
                            if (arg[0]) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
`ifdef SCRIPT_LOOP_EN
                            end else if (rep != 6'd0 && loop_q >= rep) begin
                                // Loop is used up: fall through and rearm.
                                loop_d  = 6'd0;
                                pc_d    = pc_next;
                                state_d = S_FETCH;
                            end else begin
                                if (rep != 6'd0) loop_d = loop_q + 6'd1;
                                pc_d    = arg;
                                state_d = S_FETCH;
                            end
`else
                            end else begin
                                pc_d    = arg;
                                state_d = S_FETCH;
                            end
`endif
                        end
                        default: begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_EMIT: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    pc_d        = pc_next;
                    state_d     = S_FETCH;
                end
            end
            S_WAIT: begin
                // The prescaler counts 0..TICK_CYCLES-1. Each time it wraps,
                // one wait unit is used up.
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (wait_q == 8'd1) begin
                        wait_d  = 8'd0;
                        pc_d    = pc_next;
                        state_d = S_FETCH;
                    end else begin
                        wait_d = wait_q - 8'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Memory loading overrides everything, including a start in the
        // same cycle.
        if (script_mode) begin
            state_d     = S_IDLE;
            pc_d        = 8'd0;
            cmd_valid_d = 1'b0;
            done_d      = 1'b0;
            wait_d      = 8'd0;
            presc_d     = '0;
`ifdef SCRIPT_LOOP_EN
            loop_d      = 6'd0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= 8'd0;
            cmd_bits_q  <= 8'd0;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wait_q      <= 8'd0;
            presc_q     <= '0;
`ifdef SCRIPT_LOOP_EN
            loop_q      <= 6'd0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cmd_bits_q  <= cmd_bits_d;
            cmd_valid_q <= cmd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            presc_q     <= presc_d;
`ifdef SCRIPT_LOOP_EN
            loop_q      <= loop_d;
`endif
        end
    end

    assign pc        = pc_q;
    assign cmd_bits  = cmd_bits_q;
    assign cmd_valid = cmd_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_script_runner.sv
// -----------------------------------------------------------------------------
// tb_script_runner
//
// Self-checking bench for script_runner, built with TICK_CYCLES = 4.
// A table of whole-script runs is checked against hand-computed command
// streams. Hand-written sequences then cover the timing corner cases.
// -----------------------------------------------------------------------------
module tb_script_runner;

    localparam int TICK = 4;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EMIT = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;

    logic        clock = 1'b0;
    logic        reset;
    logic        script_mode;
    logic [7:0]  script_num;
    logic [15:0] script;
    logic        start;
    logic [7:0]  pc;
    logic [7:0]  cmd_bits;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  state_dbg;

    logic [15:0] mem [128];
    assign script = mem[pc[7:1]];

    script_runner #(.TICK_CYCLES(TICK)) dut (
        .clock      (clock),
        .reset      (reset),
        .script_mode(script_mode),
        .script_num (script_num),
        .script     (script),
        .start      (start),
        .pc         (pc),
        .cmd_bits   (cmd_bits),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        string       name;
        logic [15:0] prog [4];
        logic [7:0]  num;
        int          ncmd;
        logic [7:0]  cmds [4];
        int          ndone;
        logic        exp_err;
    } vec_t;

`ifdef SCRIPT_LOOP_EN
    localparam int NV = 10;
`else
    localparam int NV = 9;
`endif
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_vec(input int i, input string name,
                           input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic [15:0] p3,
                           input logic [7:0] num, input int ncmd,
                           input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3,
                           input int ndone, input logic e);
        vecs[i].name    = name;
        vecs[i].prog[0] = p0;
        vecs[i].prog[1] = p1;
        vecs[i].prog[2] = p2;
        vecs[i].prog[3] = p3;
        vecs[i].num     = num;
        vecs[i].ncmd    = ncmd;
        vecs[i].cmds[0] = c0;
        vecs[i].cmds[1] = c1;
        vecs[i].cmds[2] = c2;
        vecs[i].cmds[3] = c3;
        vecs[i].ndone   = ndone;
        vecs[i].exp_err = e;
    endtask

    task automatic load(input logic [15:0] p0, input logic [15:0] p1,
                        input logic [15:0] p2, input logic [15:0] p3,
                        input logic [7:0] num);
        for (int k = 0; k < 128; k++) mem[k] = 16'h0000;
        mem[0] = p0;
        mem[1] = p1;
        mem[2] = p2;
        mem[3] = p3;
        script_num = num;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Run until busy drops (bounded), scoring accepted commands and done pulses.
    task automatic run_and_score(input string name, input int exp_done, input logic exp_err);
        int done_cnt = 0;
        bit finished = 0;
        for (int c = 0; c < 300; c++) begin
            if (done) done_cnt++;
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s extra_cmd actual=%0h required=none", name, cmd_bits);
                end else begin
                    check({name, " cmd"}, 32'(cmd_bits), 32'(exp_q.pop_front()));
                end
            end
            if (!busy) begin
                finished = 1;
                break;
            end
            step();
        end
        check({name, " finished"}, 32'(finished), 32'd1);
        check({name, " missing_cmds"}, exp_q.size(), 32'd0);
        step();
        if (done) done_cnt++;
        check({name, " done_count"}, done_cnt, exp_done);
        check({name, " err"}, 32'(err), 32'(exp_err));
        check({name, " busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input int i);
        load(vecs[i].prog[0], vecs[i].prog[1], vecs[i].prog[2], vecs[i].prog[3], vecs[i].num);
        cmd_ready = 1'b1;
        exp_q.delete();
        for (int k = 0; k < vecs[i].ncmd; k++) exp_q.push_back(vecs[i].cmds[k]);
        pulse_start();
        run_and_score(vecs[i].name, vecs[i].ndone, vecs[i].exp_err);
    endtask

    initial begin
        int  n;
        bit  ok;
        bit  poked;
        logic [2:0] after_wait;

        reset = 1'b1;
        script_mode = 1'b0;
        start = 1'b0;
        cmd_ready = 1'b1;
        load(16'h0, 16'h0, 16'h0, 16'h0, 8'd0);

        set_vec(0, "two_cmds_halt", 16'h0041, 16'h0042, 16'hC000, 16'h0000, 8'd6, 2, 8'h41, 8'h42, 8'h00, 8'h00, 1, 1'b0);
        set_vec(1, "end_no_halt",   16'h0041, 16'h0042, 16'h0000, 16'h0000, 8'd4, 2, 8'h41, 8'h42, 8'h00, 8'h00, 1, 1'b0);
        set_vec(2, "odd_jump",      16'h8003, 16'h0000, 16'h0000, 16'h0000, 8'd8, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1);
        set_vec(3, "wait0_cmds",    16'h0011, 16'h4000, 16'h0022, 16'hC000, 8'd8, 2, 8'h11, 8'h22, 8'h00, 8'h00, 1, 1'b0);
        set_vec(4, "jump_skip",     16'h8004, 16'h0099, 16'h0033, 16'hC000, 8'd8, 1, 8'h33, 8'h00, 8'h00, 8'h00, 1, 1'b0);
        set_vec(5, "num_lt_2",      16'h0041, 16'h0000, 16'h0000, 16'h0000, 8'd1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b0);
        set_vec(6, "odd_num",       16'h0077, 16'h0055, 16'h0000, 16'h0000, 8'd3, 1, 8'h77, 8'h00, 8'h00, 8'h00, 1, 1'b0);
        set_vec(7, "halt_first",    16'hC000, 16'h0001, 16'h0002, 16'h0000, 8'd8, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b0);
        set_vec(8, "wait1_arg_lo",  16'h4001, 16'h3F5A, 16'hC000, 16'h0000, 8'd6, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 1, 1'b0);
`ifdef SCRIPT_LOOP_EN
        set_vec(9, "loop_n2",       16'h0010, 16'h8200, 16'h0020, 16'hC000, 8'd8, 4, 8'h10, 8'h10, 8'h10, 8'h20, 1, 1'b0);
`endif

        // Values while reset is held, then after release.
        step();
        step();
        check("rst pc", 32'(pc), 32'h0);
        check("rst cmd_bits", 32'(cmd_bits), 32'h0);
        check("rst cmd_valid", 32'(cmd_valid), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst done", 32'(done), 32'h0);
        check("rst err", 32'(err), 32'h0);
        check("rst state", 32'(state_dbg), 32'(ST_IDLE));
        reset = 1'b0;
        step();
        check("post_rst busy", 32'(busy), 32'h0);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Latency and backpressure: CMD 0x55 held against cmd_ready = 0.
        load(16'h0055, 16'hC000, 16'h0, 16'h0, 8'd4);
        cmd_ready = 1'b0;
        pulse_start();
        check("lat c1 valid", 32'(cmd_valid), 32'h0);
        step();
        check("lat c2 valid", 32'(cmd_valid), 32'h0);
        step();
        check("lat c3 valid", 32'(cmd_valid), 32'h1);
        check("lat c3 bits", 32'(cmd_bits), 32'h55);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp valid", 32'(cmd_valid), 32'h1);
            check("bp bits", 32'(cmd_bits), 32'h55);
            check("bp pc", 32'(pc), 32'h0);
        end
        cmd_ready = 1'b1;
        step();
        check("accept valid", 32'(cmd_valid), 32'h0);
        check("accept pc", 32'(pc), 32'h2);
        exp_q.delete();
        run_and_score("bp_tail", 1, 1'b0);

        // WAIT arg = 3 stays in WAIT for exactly 3 * TICK clocks, then fetches.
        load(16'h4003, 16'hC000, 16'h0, 16'h0, 8'd4);
        pulse_start();
        n = 0;
        after_wait = ST_IDLE;
        for (int c = 0; c < 60 && busy; c++) begin
            if (state_dbg == ST_WAIT) n++;
            else if (n > 0 && after_wait == ST_IDLE) after_wait = state_dbg;
            step();
        end
        check("wait3 cycles", n, 32'd12);
        check("wait3 next", 32'(after_wait), 32'(ST_FETCH));

        // WAIT arg = 0 never enters WAIT.
        load(16'h4000, 16'hC000, 16'h0, 16'h0, 8'd4);
        pulse_start();
        n = 0;
        for (int c = 0; c < 60 && busy; c++) begin
            if (state_dbg == ST_WAIT) n++;
            step();
        end
        check("wait0 cycles", n, 32'd0);
        check("wait0 done_state busy", 32'(busy), 32'h0);

        // script_mode raised while a command is pending in EMIT at pc = 2.
        load(16'h4000, 16'h0066, 16'hC000, 16'h0, 8'd6);
        cmd_ready = 1'b0;
        pulse_start();
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            if (cmd_valid) begin
                ok = 1;
                break;
            end
            step();
        end
        check("mode pre valid", 32'(ok), 32'h1);
        check("mode pre pc", 32'(pc), 32'h2);
        check("mode pre state", 32'(state_dbg), 32'(ST_EMIT));
        script_mode = 1'b1;
        step();
        check("mode valid", 32'(cmd_valid), 32'h0);
        check("mode state", 32'(state_dbg), 32'(ST_IDLE));
        check("mode pc", 32'(pc), 32'h0);
        check("mode done", 32'(done), 32'h0);
        // start in the same cycle as script_mode is ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        script_mode = 1'b0;
        check("mode+start busy", 32'(busy), 32'h0);
        check("mode+start done", 32'(done), 32'h0);
        step();
        check("mode+start later busy", 32'(busy), 32'h0);
        cmd_ready = 1'b1;

        // Asynchronous reset in the middle of a WAIT at pc = 2.
        load(16'h0012, 16'h4005, 16'hC000, 16'h0, 8'd6);
        pulse_start();
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            if (state_dbg == ST_WAIT) begin
                ok = 1;
                break;
            end
            step();
        end
        check("rstw reached wait", 32'(ok), 32'h1);
        step();
        step();
        check("rstw pre pc", 32'(pc), 32'h2);
        check("rstw pre bits", 32'(cmd_bits), 32'h12);
        #2;
        reset = 1'b1;
        #1;
        check("rstw async pc", 32'(pc), 32'h0);
        check("rstw async bits", 32'(cmd_bits), 32'h0);
        check("rstw async busy", 32'(busy), 32'h0);
        check("rstw async state", 32'(state_dbg), 32'(ST_IDLE));
        check("rstw async valid", 32'(cmd_valid), 32'h0);
        step();
        reset = 1'b0;
        step();
        check("rstw after busy", 32'(busy), 32'h0);

        // start while busy (during a WAIT at pc = 2) changes nothing.
        load(16'h0031, 16'h4002, 16'h0032, 16'hC000, 8'd8);
        exp_q.delete();
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        pulse_start();
        poked = 0;
        for (int c = 0; c < 100; c++) begin
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_start extra_cmd actual=%0h required=none", cmd_bits);
                end else begin
                    check("busy_start cmd", 32'(cmd_bits), 32'(exp_q.pop_front()));
                end
            end
            if (!poked && state_dbg == ST_WAIT) begin
                poked = 1;
                start = 1'b1;
                step();
                start = 1'b0;
                check("busy_start pc", 32'(pc), 32'h2);
                check("busy_start state", 32'(state_dbg), 32'(ST_WAIT));
            end else if (!busy) begin
                break;
            end else begin
                step();
            end
        end
        check("busy_start poked", 32'(poked), 32'h1);
        run_and_score("busy_start", 1, 1'b0);

`ifndef SCRIPT_LOOP_EN
        // Without the loop feature the repeat field is ignored: the jump
        // loops forever, re-emitting 0x10 with no completion.
        load(16'h0010, 16'h8200, 16'h0020, 16'hC000, 8'd8);
        pulse_start();
        n = 0;
        ok = 1;
        for (int c = 0; c < 40; c++) begin
            if (cmd_valid && cmd_ready) begin
                n++;
                if (cmd_bits != 8'h10) ok = 0;
            end
            if (done) ok = 0;
            step();
        end
        check("noloop all_0x10_no_done", 32'(ok), 32'h1);
        check("noloop repeats", 32'(n >= 5), 32'h1);
        check("noloop busy", 32'(busy), 32'h1);
        script_mode = 1'b1;
        step();
        script_mode = 1'b0;
        check("noloop abort busy", 32'(busy), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
